// File: rtl/mem_access_stage.sv
// MEM pipeline stage: multi-cycle word-addressed data RAM with byte/half/word access and stall FSM.
// Optional MEM_PERF_EN adds load/store/stall performance counters.
module mem_access_stage #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned AW      = 8,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [2:0]  mop,
  input  logic [4:0]  mrd,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  output logic        stall,
  output logic        o_wreg,
  output logic        o_m2reg,
  output logic [4:0]  o_rd,
  output logic [31:0] o_r,
  output logic [31:0] o_data,
`ifdef MEM_PERF_EN
  output logic [31:0] load_cnt,
  output logic [31:0] store_cnt,
  output logic [31:0] stall_cnt,
`endif
  output logic        adrerr
);

  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_adrerr;
  logic [31:0]     r_mem [DEPTH];

  logic [AW-1:0]   w_idx;
  logic            w_memop;
  logic            w_is_half;
  logic            w_is_byte;
  logic            w_misalign;
  logic            w_mem_done;
  logic            w_valid;
  logic            w_fire;
  logic            w_st_we;
  logic            w_ld_ok;
  logic [3:0]      w_wmask;
  logic [31:0]     w_wdata;
  logic [31:0]     w_word;
  logic [15:0]     w_half;
  logic [7:0]      w_byte;
  logic [31:0]     w_load;
  logic            w_unused_bits;

  assign w_idx      = malu[AW+1:2];
  assign w_memop    = mm2reg | mwmem;
  assign w_is_half  = (mop == 3'd1) || (mop == 3'd2);
  assign w_is_byte  = (mop == 3'd3) || (mop == 3'd4);
  assign w_misalign = w_is_byte ? 1'b0 : (w_is_half ? malu[0] : (malu[1:0] != 2'b00));

  // Access completes in the presenting cycle for MEM_LAT=1, else on the last WAIT count.
  assign w_mem_done = (MEM_LAT == 1) || ((r_state == S_WAIT) && (r_cnt == LAST));
  assign w_valid    = reset && (!w_memop || w_mem_done);
  assign w_fire     = reset && w_memop && w_mem_done;
  assign w_st_we    = w_fire && mwmem && !w_misalign;
  assign w_ld_ok    = mm2reg && !mwmem && !w_misalign;
  assign stall      = reset && w_memop && !w_mem_done;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_adrerr <= 1'b0;
    end else begin
      if (w_fire && w_misalign) r_adrerr <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_memop && (MEM_LAT > 1)) begin
            r_state <= S_WAIT;
            r_cnt   <= CW'(1);
          end
        end
        S_WAIT: begin
          if (r_cnt == LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Store lanes: data is replicated so each enabled lane picks its slice directly.
  always_comb begin
    w_wmask = 4'b1111;
    w_wdata = mb;
    if (w_is_half) begin
      w_wmask = malu[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{mb[15:0]}};
    end else if (w_is_byte) begin
      w_wmask = 4'b0001 << malu[1:0];
      w_wdata = {4{mb[7:0]}};
    end
  end

  always_ff @(posedge clock) begin
    if (w_st_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wmask[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign w_word = r_mem[w_idx];

  always_comb begin
    w_half = malu[1] ? w_word[31:16] : w_word[15:0];
    case (malu[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    case (mop)
      3'd1:    w_load = {{16{w_half[15]}}, w_half};
      3'd2:    w_load = {16'h0000, w_half};
      3'd3:    w_load = {{24{w_byte[7]}}, w_byte};
      3'd4:    w_load = {24'h000000, w_byte};
      default: w_load = w_word;
    endcase
  end

  assign o_wreg   = w_valid && mwreg && !(w_memop && w_misalign);
  assign o_m2reg  = w_valid && mm2reg;
  assign o_rd     = w_valid ? mrd : 5'd0;
  assign o_r      = w_valid ? malu : 32'd0;
  assign o_data   = (w_valid && w_ld_ok) ? w_load : 32'd0;
  assign adrerr   = r_adrerr;

  assign w_unused_bits = ^malu[31:AW+2];

`ifdef MEM_PERF_EN
  logic [31:0] r_load_cnt;
  logic [31:0] r_store_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_load_cnt  <= '0;
      r_store_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_fire && w_ld_ok) r_load_cnt <= r_load_cnt + 32'd1;
      if (w_st_we) r_store_cnt <= r_store_cnt + 32'd1;
      if (stall) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign load_cnt  = r_load_cnt;
  assign store_cnt = r_store_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
